dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 60 ++++++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared size encodings, FSM state type and lane helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Size code 2'b11 falls into the default arm everywhere, i.e. behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write, registered read, contents never reset.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: response LATENCY+1 cycles after acceptance, held until resp_ready.
// DMEM_MISALIGN_CHECK_EN flags misaligned half/word accesses instead of silently aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned AB = AW + 2;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t          state_d, state_q;
  logic [3:0]      cnt_d, cnt_q;
  logic            we_d, we_q;
  logic [AB-1:0]   addr_d, addr_q;
  logic [31:0]     wdata_d, wdata_q;
  logic [1:0]      size_d, size_q;
  logic            uns_d, uns_q;
  logic            mem_en;

  logic            a_we;
  logic [AB-1:0]   a_addr;
  logic [31:0]     a_wdata;
  logic [1:0]      a_size;
  logic            a_err, r_err;
  logic [1:0]      a_lo, r_lo;
  logic [31:0]     arr_rdata;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AB];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    mem_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[AB-1:0];
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            mem_en  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          mem_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  // With zero latency the access fires on the acceptance edge, before the capture registers load.
  assign a_we    = (state_q == IDLE) ? req_we            : we_q;
  assign a_addr  = (state_q == IDLE) ? req_addr[AB-1:0]  : addr_q;
  assign a_wdata = (state_q == IDLE) ? req_wdata         : wdata_q;
  assign a_size  = (state_q == IDLE) ? req_size          : size_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign a_err = is_misaligned(a_size, a_addr[1:0]);
  assign a_lo  = a_addr[1:0];
  assign r_err = is_misaligned(size_q, addr_q[1:0]);
  assign r_lo  = addr_q[1:0];
`else
  assign a_err = 1'b0;
  assign a_lo  = force_align(a_size, a_addr[1:0]);
  assign r_err = 1'b0;
  assign r_lo  = force_align(size_q, addr_q[1:0]);
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_en & a_we & ~a_err),
    .re    (mem_en & ~a_we),
    .be    (byte_en(a_size, a_lo)),
    .addr  (a_addr[AB-1:2]),
    .wdata (lane_wdata(a_size, a_wdata)),
    .rdata (arr_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & r_err;
  assign resp_rdata = (resp_valid && !we_q && !r_err) ? load_ext(arr_rdata, size_q, r_lo, uns_q)
                                                      : 32'h0;

endmodule
